// File: rtl/password_lock_ctrl.sv
// -----------------------------------------------------------------------------
// password_lock_ctrl
//
// Password-lock controller placed between a PS/2 keyboard decoder and a
// seven-segment display driver. Characters are shifted into an entry
// register. The entry is compared against NUM_PASSWORDS stored slots. Failed
// tries consume attempts, and running out of attempts starts a timed lockout.
// New passwords can be stored only while unlocked. They go into a ring of
// slots that overwrites the oldest one.
//
// Ports
//   clock            system clock, all logic on the rising edge
//   reset            synchronous, active-high reset
//   keyCode          last character from the keyboard decoder
//   addLetter        pulse: shift keyCode into the top character of entry
//   clearEntry       pulse: reset entry to all DEFAULT_CHAR
//   tryPassword      pulse: compare entry against every stored slot
//   addPassword      pulse: store entry into the next slot (unlocked only)
//   lockNow          pulse: leave the unlocked state
//   entry            current entry, to the display
//   isValidPassword  high while unlocked
//   locked           high while in lockout
//   attemptsLeft     remaining tries before lockout
//   attemptLeds      thermometer decode of attemptsLeft, LSB-filled
// -----------------------------------------------------------------------------
module password_lock_ctrl #(
  parameter int unsigned           NUM_PASSWORDS  = 2,
  parameter int unsigned           PASS_LEN       = 6,
  parameter int unsigned           CHAR_W         = 8,
  parameter logic [CHAR_W-1:0]     DEFAULT_CHAR   = 8'h45,
  parameter int unsigned           MAX_ATTEMPTS   = 3,
  parameter int unsigned           LOCKOUT_CYCLES = 50000000
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [CHAR_W-1:0]                     keyCode,
  input  logic                                  addLetter,
  input  logic                                  clearEntry,
  input  logic                                  tryPassword,
  input  logic                                  addPassword,
  input  logic                                  lockNow,
  output logic [PASS_LEN*CHAR_W-1:0]            entry,
  output logic                                  isValidPassword,
  output logic                                  locked,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]     attemptsLeft,
  output logic [MAX_ATTEMPTS-1:0]               attemptLeds
);

  localparam int unsigned ENTRY_W = PASS_LEN * CHAR_W;
  localparam int unsigned ATT_W   = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned CNT_W   = $clog2(LOCKOUT_CYCLES + 1);
  localparam int unsigned PTR_W   = (NUM_PASSWORDS > 1) ? $clog2(NUM_PASSWORDS) : 1;

  localparam logic [ENTRY_W-1:0] DEFAULT_ENTRY = {PASS_LEN{DEFAULT_CHAR}};
  localparam logic [ATT_W-1:0]   MAX_ATT       = ATT_W'(MAX_ATTEMPTS);
  localparam logic [CNT_W-1:0]   LOCK_LOAD     = CNT_W'(LOCKOUT_CYCLES);
  localparam logic [PTR_W-1:0]   LAST_SLOT     = PTR_W'(NUM_PASSWORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    UNLOCKED,
    LOCKOUT
  } state_t;

  state_t               state;
  logic [ENTRY_W-1:0]   slots [NUM_PASSWORDS];
  logic [PTR_W-1:0]     ptr;
  logic [CNT_W-1:0]     lock_cnt;

  logic                 match;
  logic [ENTRY_W+CHAR_W-1:0] shift_src;
  logic [ENTRY_W-1:0]   entry_shifted;

  // Parallel compare of the current (pre-update) entry against every slot.
  always_comb begin
    match = 1'b0;
    for (int unsigned i = 0; i < NUM_PASSWORDS; i++) begin
      if (slots[i] == entry) begin
        match = 1'b1;
      end
    end
  end

  // The new character lands in the most-significant slot. Building the
  // shift from a widened vector keeps the slice legal even when PASS_LEN==1.
  always_comb begin
    shift_src     = {keyCode, entry};
    entry_shifted = shift_src[ENTRY_W+CHAR_W-1:CHAR_W];
  end

  // Thermometer decode of the registered attempt count.
  always_comb begin
    attemptLeds = '0;
    for (int unsigned i = 0; i < MAX_ATTEMPTS; i++) begin
      attemptLeds[i] = (32'(attemptsLeft) > i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      entry           <= DEFAULT_ENTRY;
      for (int unsigned i = 0; i < NUM_PASSWORDS; i++) begin
        slots[i] <= DEFAULT_ENTRY;
      end
      ptr             <= '0;
      attemptsLeft    <= MAX_ATT;
      isValidPassword <= 1'b0;
      locked          <= 1'b0;
      lock_cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          // The highest-priority pulse owns the cycle. A lockNow or
          // addPassword here is a no-op that still drops lower pulses.
          if (lockNow) begin
            // ignored while locked
          end else if (tryPassword) begin
            if (match) begin
              state           <= UNLOCKED;
              isValidPassword <= 1'b1;
              attemptsLeft    <= MAX_ATT;
            end else if (attemptsLeft > ATT_W'(1)) begin
              attemptsLeft <= attemptsLeft - 1'b1;
            end else begin
              state        <= LOCKOUT;
              attemptsLeft <= '0;
              locked       <= 1'b1;
              lock_cnt     <= LOCK_LOAD;
            end
          end else if (addPassword) begin
            // storing requires the unlocked state
          end else if (clearEntry) begin
            entry <= DEFAULT_ENTRY;
          end else if (addLetter) begin
            entry <= entry_shifted;
          end
        end

        UNLOCKED: begin
          if (lockNow) begin
            state           <= IDLE;
            isValidPassword <= 1'b0;
            entry           <= DEFAULT_ENTRY;
          end else if (tryPassword) begin
            // already unlocked
          end else if (addPassword) begin
            for (int unsigned i = 0; i < NUM_PASSWORDS; i++) begin
              if (ptr == PTR_W'(i)) begin
                slots[i] <= entry;
              end
            end
            ptr <= (ptr == LAST_SLOT) ? '0 : ptr + 1'b1;
          end else if (clearEntry) begin
            entry <= DEFAULT_ENTRY;
          end else if (addLetter) begin
            entry <= entry_shifted;
          end
        end

        LOCKOUT: begin
          // Exiting on the cycle the counter reads 1 makes the lockout
          // span exactly LOCKOUT_CYCLES cycles.
          if (lock_cnt == CNT_W'(1)) begin
            state        <= IDLE;
            locked       <= 1'b0;
            attemptsLeft <= MAX_ATT;
            lock_cnt     <= '0;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_password_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_password_lock_ctrl
//
// Directed scenarios followed by randomized pulses. Every cycle is compared
// against a behavioural model that keeps the entry as an array of characters,
// the slots as a ring of such arrays, and the lockout as an absolute end time.
// -----------------------------------------------------------------------------
module tb_password_lock_ctrl;

  localparam int N   = 2;
  localparam int L   = 6;
  localparam int W   = 8;
  localparam int MA  = 3;
  localparam int LC  = 10;
  localparam int EW  = L * W;
  localparam int AW  = $clog2(MA + 1);
  localparam logic [7:0] DCH = 8'h45;

  logic          clock = 1'b0;
  logic          reset;
  logic [W-1:0]  keyCode;
  logic          addLetter, clearEntry, tryPassword, addPassword, lockNow;
  logic [EW-1:0] entry;
  logic          isValidPassword, locked;
  logic [AW-1:0] attemptsLeft;
  logic [MA-1:0] attemptLeds;

  always #5 clock = ~clock;

  password_lock_ctrl #(
    .NUM_PASSWORDS  (N),
    .PASS_LEN       (L),
    .CHAR_W         (W),
    .DEFAULT_CHAR   (DCH),
    .MAX_ATTEMPTS   (MA),
    .LOCKOUT_CYCLES (LC)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .keyCode         (keyCode),
    .addLetter       (addLetter),
    .clearEntry      (clearEntry),
    .tryPassword     (tryPassword),
    .addPassword     (addPassword),
    .lockNow         (lockNow),
    .entry           (entry),
    .isValidPassword (isValidPassword),
    .locked          (locked),
    .attemptsLeft    (attemptsLeft),
    .attemptLeds     (attemptLeds)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural reference ----------------
  logic [7:0] m_entry [L];      // index 0 = least-significant character
  logic [7:0] m_slot  [N][L];
  int         m_ptr, m_att, cyc, lock_end;
  bit         m_unl, m_lock;

  function automatic logic [EW-1:0] m_packed();
    logic [EW-1:0] p;
    for (int i = 0; i < L; i++) p[i*W +: W] = m_entry[i];
    return p;
  endfunction

  function automatic bit m_match();
    for (int s = 0; s < N; s++) begin
      bit same = 1'b1;
      for (int c = 0; c < L; c++) if (m_slot[s][c] != m_entry[c]) same = 1'b0;
      if (same) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic m_clear();
    for (int c = 0; c < L; c++) m_entry[c] = DCH;
  endtask

  task automatic m_edge(input bit rst, lk, tr, ad, cl, al, input logic [7:0] kc);
    if (rst) begin
      m_clear();
      for (int s = 0; s < N; s++) for (int c = 0; c < L; c++) m_slot[s][c] = DCH;
      m_ptr = 0; m_att = MA; m_unl = 0; m_lock = 0;
    end else if (m_lock) begin
      if (cyc == lock_end) begin
        m_lock = 0;
        m_att  = MA;
      end
    end else if (lk) begin
      if (m_unl) begin
        m_unl = 0;
        m_clear();
      end
    end else if (tr) begin
      if (!m_unl) begin
        if (m_match()) begin
          m_unl = 1; m_att = MA;
        end else if (m_att > 1) begin
          m_att--;
        end else begin
          m_att = 0; m_lock = 1; lock_end = cyc + LC;
        end
      end
    end else if (ad) begin
      if (m_unl) begin
        for (int c = 0; c < L; c++) m_slot[m_ptr][c] = m_entry[c];
        m_ptr = (m_ptr + 1) % N;
      end
    end else if (cl) begin
      m_clear();
    end else if (al) begin
      for (int c = 0; c < L - 1; c++) m_entry[c] = m_entry[c+1];
      m_entry[L-1] = kc;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit rst, lk, tr, ad, cl, al, input logic [7:0] kc);
    logic [MA-1:0] leds;
    reset = rst; lockNow = lk; tryPassword = tr; addPassword = ad;
    clearEntry = cl; addLetter = al; keyCode = kc;
    @(posedge clock);
    cyc++;
    m_edge(rst, lk, tr, ad, cl, al, kc);
    #1;
    reset = 0; lockNow = 0; tryPassword = 0; addPassword = 0;
    clearEntry = 0; addLetter = 0;
    leds = MA'((1 << m_att) - 1);
    check("entry",    64'(entry),           64'(m_packed()));
    check("valid",    64'(isValidPassword), 64'(m_unl));
    check("locked",   64'(locked),          64'(m_lock));
    check("attempts", 64'(attemptsLeft),    64'(m_att));
    check("leds",     64'(attemptLeds),     64'(leds));
  endtask

  task automatic idle();           step(0, 0, 0, 0, 0, 0, 8'h00); endtask
  task automatic press(input logic [7:0] k); step(0, 0, 0, 0, 0, 1, k); endtask
  task automatic try_pw();         step(0, 0, 1, 0, 0, 0, 8'h00); endtask
  task automatic add_pw();         step(0, 0, 0, 1, 0, 0, 8'h00); endtask
  task automatic clr();            step(0, 0, 0, 0, 1, 0, 8'h00); endtask
  task automatic lock_now();       step(0, 1, 0, 0, 0, 0, 8'h00); endtask
  task automatic do_reset();       step(1, 0, 0, 0, 0, 0, 8'h00); endtask
  task automatic type6(input logic [7:0] k);
    for (int i = 0; i < 6; i++) press(k);
  endtask

  logic [7:0]    seq [6];
  logic [EW-1:0] frozen;
  logic [EW-1:0] ent_c;
  int            lock_count;

  initial begin
    reset = 0; keyCode = '0; addLetter = 0; clearEntry = 0;
    tryPassword = 0; addPassword = 0; lockNow = 0; cyc = 0;
    seq[0] = 8'h16; seq[1] = 8'h1E; seq[2] = 8'h26;
    seq[3] = 8'h25; seq[4] = 8'h2E; seq[5] = 8'h36;

    // reset state
    do_reset();
    do_reset();
    check("rst_entry",    64'(entry), 64'({6{8'h45}}));
    check("rst_attempts", 64'(attemptsLeft), 64'd3);
    check("rst_leds",     64'(attemptLeds), 64'b111);

    // default entry matches the default slots
    try_pw();
    check("dflt_unlock", 64'(isValidPassword), 64'd1);
    check("dflt_leds",   64'(attemptLeds), 64'b111);

    // program a password, relock, retype it
    for (int i = 0; i < 6; i++) press(seq[i]);
    check("seq_entry", 64'(entry), 64'h36_2E_25_26_1E_16);
    add_pw();
    lock_now();
    check("relock_entry", 64'(entry), 64'({6{8'h45}}));
    check("relock_valid", 64'(isValidPassword), 64'd0);
    for (int i = 0; i < 6; i++) press(seq[i]);
    try_pw();
    check("retype_unlock", 64'(isValidPassword), 64'd1);

    // three failures lead to lockout
    lock_now();
    press(8'h11);
    try_pw();
    check("fail1_att", 64'(attemptsLeft), 64'd2);
    check("fail1_leds", 64'(attemptLeds), 64'b011);
    try_pw();
    check("fail2_att", 64'(attemptsLeft), 64'd1);
    check("fail2_leds", 64'(attemptLeds), 64'b001);
    try_pw();
    check("fail3_att", 64'(attemptsLeft), 64'd0);
    check("fail3_leds", 64'(attemptLeds), 64'b000);
    check("fail3_locked", 64'(locked), 64'd1);
    frozen = entry;
    lock_count = 1;
    for (int i = 0; i < 40 && locked; i++) begin
      if (i % 2 == 0) press(8'h1C); else try_pw();
      if (locked) begin
        lock_count++;
        check("lock_frozen", 64'(entry), 64'(frozen));
      end
    end
    check("lock_len", 64'(lock_count), 64'(LC));
    check("lock_exit_att", 64'(attemptsLeft), 64'd3);
    check("lock_exit_entry", 64'(entry), 64'(frozen));

    // ring of slots: slot0 holds the programmed password, slot1 default
    clr();
    try_pw();
    check("ring_unlock", 64'(isValidPassword), 64'd1);
    type6(8'h1C); add_pw();   // A -> slot1
    type6(8'h32); add_pw();   // B -> slot0
    type6(8'h21); add_pw();   // C -> slot1
    lock_now();
    type6(8'h1C); try_pw();
    check("ring_A_fails", 64'(isValidPassword), 64'd0);
    type6(8'h32); try_pw();
    check("ring_B_unlocks", 64'(isValidPassword), 64'd1);
    lock_now();
    type6(8'h21); try_pw();
    check("ring_C_unlocks", 64'(isValidPassword), 64'd1);
    lock_now();

    // same-cycle try + letter: compare sees the old entry, letter dropped
    type6(8'h21);
    ent_c = entry;
    step(0, 0, 1, 0, 0, 1, 8'h45);
    check("combo_unlock", 64'(isValidPassword), 64'd1);
    check("combo_entry", 64'(entry), 64'(ent_c));
    lock_now();

    // addPassword while locked leaves the slots alone
    type6(8'h1C);
    add_pw();
    try_pw();
    check("idle_add_ignored", 64'(isValidPassword), 64'd0);

    // reset in the middle of a lockout
    for (int i = 0; i < 4 && !locked; i++) try_pw();
    check("pre_rst_locked", 64'(locked), 64'd1);
    for (int i = 0; i < 5; i++) idle();
    do_reset();
    check("midlock_rst_locked", 64'(locked), 64'd0);
    check("midlock_rst_att", 64'(attemptsLeft), 64'd3);
    try_pw();
    check("midlock_rst_slots", 64'(isValidPassword), 64'd1);

    // randomized single pulses
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] k;
      r = $urandom_range(0, 299);
      case ($urandom_range(0, 2))
        0: k = 8'h16;
        1: k = 8'h1E;
        default: k = 8'h45;
      endcase
      if (r == 0)       do_reset();
      else if (r < 15)  lock_now();
      else if (r < 60)  try_pw();
      else if (r < 80)  add_pw();
      else if (r < 110) clr();
      else if (r < 240) press(k);
      else              idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/password_lock_ctrl.md
Name: password_lock_ctrl

Overview:
Clocked, parametrised password-lock controller.
- Accumulates keyboard characters into a PASS_LEN-character entry register and compares it against NUM_PASSWORDS stored passwords.
- Tracks remaining attempts and enforces a timed lockout.
- Allows password programming only while unlocked.
- Sits between the PS/2 keyboard decoder (keyCode) and the seven-segment display driver (entry), with status to LEDs.

Parameters:
NUM_PASSWORDS, 2, number of stored password slots (>=1)
PASS_LEN, 6, characters per password (>=1)
CHAR_W, 8, bits per character (scan code width)
DEFAULT_CHAR, 8'h45, reset/clear value of every character ('0' scan code)
MAX_ATTEMPTS, 3, failed tries allowed before lockout (>=1)
LOCKOUT_CYCLES, 50000000, clock cycles spent in lockout (>=1)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
keyCode  in  CHAR_W  last character from keyboard decoder
addLetter  in  1  one-cycle pulse: shift keyCode into entry
clearEntry  in  1  one-cycle pulse: reset entry to defaults
tryPassword  in  1  one-cycle pulse: compare entry against stored slots
addPassword  in  1  one-cycle pulse: store entry into next slot (UNLOCKED only)
lockNow  in  1  one-cycle pulse: leave UNLOCKED
entry  out  PASS_LEN*CHAR_W  current entry, to display
isValidPassword  out  1  high while UNLOCKED
locked  out  1  high while LOCKOUT
attemptsLeft  out  clog2(MAX_ATTEMPTS+1)  remaining tries
attemptLeds  out  MAX_ATTEMPTS  thermometer of attemptsLeft, LSB-filled (3 -> 111, 1 -> 001)

Behaviour:
- Inputs are synchronous single-cycle pulses. Debounce and synchronisation are the caller's job.
- All outputs are registered. Every effect is visible the cycle after the pulse is sampled.
- Reset (takes priority over everything, including mid-lockout):
  - state=IDLE
  - entry and all slots = PASS_LEN x DEFAULT_CHAR
  - write pointer=0, attemptsLeft=MAX_ATTEMPTS, isValidPassword=0, locked=0, lockout counter=0
- One action per cycle. Priority: lockNow > tryPassword > addPassword > clearEntry > addLetter. Lower-priority pulses in the same cycle are dropped.
- addLetter:
  - entry <= {keyCode, entry[PASS_LEN*CHAR_W-1 : CHAR_W]}.
  - New character enters the most-significant character slot; the least-significant character is discarded.
  - Allowed in IDLE and UNLOCKED.
- clearEntry: entry <= all DEFAULT_CHAR. Allowed in IDLE and UNLOCKED.
- State IDLE:
  - tryPassword:
    - Compare the full entry against all slots in parallel, combinationally in one cycle.
    - Any match: -> UNLOCKED, isValidPassword=1, attemptsLeft=MAX_ATTEMPTS.
    - No match with attemptsLeft>1: attemptsLeft-1, stay IDLE.
    - No match with attemptsLeft==1: attemptsLeft=0, -> LOCKOUT, locked=1, counter=LOCKOUT_CYCLES.
  - addPassword and lockNow are ignored.
- State UNLOCKED:
  - addPassword:
    - slot[ptr] <= entry.
    - ptr <= (ptr==NUM_PASSWORDS-1) ? 0 : ptr+1, i.e. wraps and overwrites the oldest slot.
    - Stays UNLOCKED.
  - lockNow: -> IDLE, isValidPassword=0, entry <= all DEFAULT_CHAR.
  - tryPassword is ignored.
- State LOCKOUT:
  - All pulses are ignored, and entry is frozen.
  - Counter decrements once per cycle.
  - In the cycle the counter reads 1 it transitions to: IDLE, locked=0, attemptsLeft=MAX_ATTEMPTS.
  - LOCKOUT therefore lasts exactly LOCKOUT_CYCLES cycles.
- attemptLeds is a pure decode of the registered attemptsLeft: bit i = (attemptsLeft > i).
- Duplicate slots are legal. A match on any slot unlocks.

Test Plan:
- Reset, then tryPassword with default entry (6x 8'h45) -> next cycle isValidPassword=1, attemptsLeft=3, attemptLeds=111.
- Unlocked: addLetter x6 with 16,1E,26,25,2E,36 -> entry=48'h36_2E_25_26_1E_16. addPassword, then lockNow -> entry=all 45, isValidPassword=0. Retype the same six letters and tryPassword -> unlocked.
- From IDLE with a wrong entry, three tryPassword pulses -> attemptsLeft 2,1,0 and attemptLeds 011,001,000. locked=1 after the third. With LOCKOUT_CYCLES=10, locked is high for exactly 10 cycles, then attemptsLeft=3. addLetter/tryPassword during lockout leave entry and state unchanged.
- With NUM_PASSWORDS=2, three addPassword pulses with entries A,B,C -> slots hold C,B. A fails, B and C unlock.
- Same-cycle tryPassword+addLetter in IDLE -> compare uses the pre-update entry and the letter is dropped. addPassword in IDLE -> slots unchanged.
- Assert reset mid-lockout (counter=5) -> next cycle locked=0, IDLE, attemptsLeft=3, all slots default.
